// File: rtl/nyan_song_sequencer.sv
// Chiptune song sequencer: counts frame ticks into beats, fetches each beat's notes
// from the song ROM and runs the melody/bass volume envelopes.
module nyan_song_sequencer #(
  parameter int SONG_LEN       = 288,
  parameter int TICKS_PER_BEAT = 6,
  parameter int ADDR_W         = 9,
  parameter int VOL_MAX        = 63,
  parameter int MEL_DECAY_SH   = 3,
  parameter int BASS_DECAY_SH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_stb,
  input  logic              run,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [ADDR_W-1:0] songpos,
  output logic [2:0]        melody_note,
  output logic [1:0]        melody_oct,
  output logic [2:0]        bass_note,
  output logic [1:0]        bass_oct,
  output logic [5:0]        melody_vol,
  output logic [5:0]        bass_vol,
  output logic              beat_stb,
  output logic              busy
);

  localparam int CTR_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LATCH} state_t;

  state_t             state;
  logic [CTR_W-1:0]   beat_ctr;
  logic [ADDR_W-1:0]  songpos_next;
  logic               tick;
  logic               last_tick;

  function automatic logic [5:0] mel_decay(input logic [5:0] v);
    return v - (v >> MEL_DECAY_SH);
  endfunction

  function automatic logic [5:0] bass_decay(input logic [5:0] v);
    return v - (v >> BASS_DECAY_SH);
  endfunction

  assign tick         = tick_stb & run;
  assign last_tick    = (beat_ctr == CTR_W'(TICKS_PER_BEAT - 1));
  assign songpos_next = (songpos == ADDR_W'(SONG_LEN - 1)) ? '0 : songpos + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      beat_ctr    <= '0;
      songpos     <= ADDR_W'(SONG_LEN - 1);
      rom_rd      <= 1'b0;
      rom_addr    <= '0;
      melody_note <= '0;
      melody_oct  <= '0;
      bass_note   <= '0;
      bass_oct    <= '0;
      melody_vol  <= '0;
      bass_vol    <= '0;
      beat_stb    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rom_rd   <= 1'b0;
      beat_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            if (last_tick) begin
              // Beat tick: start the ROM read; envelopes hold until the trigger lands.
              beat_ctr <= '0;
              rom_addr <= songpos_next;
              rom_rd   <= 1'b1;
              busy     <= 1'b1;
              state    <= FETCH;
            end else begin
              beat_ctr   <= beat_ctr + 1'b1;
              melody_vol <= mel_decay(melody_vol);
              bass_vol   <= bass_decay(bass_vol);
            end
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          songpos     <= rom_addr;
          melody_oct  <= rom_data[10:9];
          melody_note <= rom_data[8:6];
          bass_oct    <= rom_data[4:3];
          bass_note   <= rom_data[2:0];
          if (rom_data[11]) melody_vol <= 6'(VOL_MAX);
          if (rom_data[5])  bass_vol   <= 6'(VOL_MAX);
          beat_stb    <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
